// File: rtl/attn_qk_spike_feeder_if.sv
// Spike feeder bus: control, Q/K RAM read ports and the PE beat stream.
// The master modport is the feeder side, and the slave modport is the environment (RAMs, PE, controller).
interface attn_qk_spike_feeder_if #(
  parameter int UNIT_NUM   = 16,
  parameter int TIME_STEPS = 4,
  parameter int CHUNKS     = 12,
  parameter int TOKENS     = 64
);
  localparam int W  = 2 * UNIT_NUM * TIME_STEPS;
  localparam int AW = $clog2(TOKENS * CHUNKS);
  localparam int KW = $clog2(TOKENS);

  logic          i_start;
  // One extra bit so that an out-of-range query index can be represented and flagged.
  logic [KW:0]   i_q_token;
  logic          i_hold;
  logic          o_busy;
  logic          o_done;
  logic          o_err;
  logic          o_q_rd_en;
  logic [AW-1:0] o_q_rd_addr;
  logic [W-1:0]  i_q_rd_data;
  logic          o_k_rd_en;
  logic [AW-1:0] o_k_rd_addr;
  logic [W-1:0]  i_k_rd_data;
  logic          o_Spikesdata_valid;
  logic [W-1:0]  o_SpikesdataQuery;
  logic [W-1:0]  o_SpikesdataKey;
  logic [KW-1:0] o_key_idx;
  logic          o_last_chunk;
  logic          o_last_key;

  modport master (
    input  i_start, i_q_token, i_hold, i_q_rd_data, i_k_rd_data,
    output o_busy, o_done, o_err, o_q_rd_en, o_q_rd_addr, o_k_rd_en, o_k_rd_addr,
           o_Spikesdata_valid, o_SpikesdataQuery, o_SpikesdataKey,
           o_key_idx, o_last_chunk, o_last_key
  );

  modport slave (
    output i_start, i_q_token, i_hold, i_q_rd_data, i_k_rd_data,
    input  o_busy, o_done, o_err, o_q_rd_en, o_q_rd_addr, o_k_rd_en, o_k_rd_addr,
           o_Spikesdata_valid, o_SpikesdataQuery, o_SpikesdataKey,
           o_key_idx, o_last_chunk, o_last_key
  );
endinterface

// File: rtl/attn_qk_spike_feeder.sv
// Streams Q/K spike row chunks for one query token over all key tokens into the attention PE array.
// state | meaning: IDLE wait start | RUN issue reads | DRAIN flush pipe | DONE one-cycle done pulse
module attn_qk_spike_feeder #(
  parameter int UNIT_NUM   = 16,
  parameter int TIME_STEPS = 4,
  parameter int CHUNKS     = 12,
  parameter int TOKENS     = 64
) (
  input logic s_clk,
  input logic s_rst,
  attn_qk_spike_feeder_if.master bus
);
  localparam int W  = 2 * UNIT_NUM * TIME_STEPS;
  localparam int AW = $clog2(TOKENS * CHUNKS);
  localparam int KW = $clog2(TOKENS);
  localparam int CW = $clog2(CHUNKS);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [CW-1:0] CHUNK_LAST = CW'(CHUNKS - 1);
  localparam logic [KW-1:0] KEY_LAST   = KW'(TOKENS - 1);

  logic [1:0]    state;
  logic [KW-1:0] q_tok;
  logic [KW-1:0] key;
  logic [CW-1:0] chunk;
  logic          err;

  logic          p1_valid;
  logic [KW-1:0] p1_key;
  logic          p1_last_chunk;
  logic          p1_last_key;

  logic          out_valid;
  logic [W-1:0]  out_query;
  logic [W-1:0]  out_key;
  logic [KW-1:0] out_key_idx;
  logic          out_last_chunk;
  logic          out_last_key;

  logic          issue;
  logic          chunk_last;
  logic          key_last;
  logic          token_ok;
  logic [AW-1:0] q_addr;
  logic [AW-1:0] k_addr;

  assign issue      = (state == RUN) && !bus.i_hold;
  assign chunk_last = (chunk == CHUNK_LAST);
  assign key_last   = (key == KEY_LAST);
  assign token_ok   = (bus.i_q_token < (KW+1)'(TOKENS));
  assign q_addr     = AW'(q_tok) * AW'(CHUNKS) + AW'(chunk);
  assign k_addr     = AW'(key) * AW'(CHUNKS) + AW'(chunk);

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      state <= IDLE;
      q_tok <= '0;
      key   <= '0;
      chunk <= '0;
      err   <= 1'b0;
    end else begin
      err <= (state == IDLE) && bus.i_start && !token_ok;
      case (state)
        IDLE: begin
          if (bus.i_start && token_ok) begin
            state <= RUN;
            q_tok <= bus.i_q_token[KW-1:0];
            key   <= '0;
            chunk <= '0;
          end
        end
        RUN: begin
          if (issue) begin
            if (chunk_last) begin
              chunk <= '0;
              key   <= key + 1'b1;
              if (key_last) state <= DRAIN;
            end else begin
              chunk <= chunk + 1'b1;
            end
          end
        end
        // With stage 1 empty, the final beat leaves stage 2 on this same edge, so DONE lines up
        // with the cycle right after the last valid beat.
        DRAIN:   if (!p1_valid) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      p1_valid       <= 1'b0;
      p1_key         <= '0;
      p1_last_chunk  <= 1'b0;
      p1_last_key    <= 1'b0;
      out_valid      <= 1'b0;
      out_query      <= '0;
      out_key        <= '0;
      out_key_idx    <= '0;
      out_last_chunk <= 1'b0;
      out_last_key   <= 1'b0;
    end else begin
      p1_valid      <= issue;
      p1_key        <= key;
      p1_last_chunk <= issue && chunk_last;
      p1_last_key   <= issue && chunk_last && key_last;
      out_valid     <= p1_valid;
      if (p1_valid) begin
        out_query      <= bus.i_q_rd_data;
        out_key        <= bus.i_k_rd_data;
        out_key_idx    <= p1_key;
        out_last_chunk <= p1_last_chunk;
        out_last_key   <= p1_last_key;
      end else begin
        out_key_idx    <= '0;
        out_last_chunk <= 1'b0;
        out_last_key   <= 1'b0;
      end
    end
  end

  assign bus.o_busy             = (state != IDLE);
  assign bus.o_done             = (state == DONE);
  assign bus.o_err              = err;
  assign bus.o_q_rd_en          = issue;
  assign bus.o_k_rd_en          = issue;
  assign bus.o_q_rd_addr        = issue ? q_addr : '0;
  assign bus.o_k_rd_addr        = issue ? k_addr : '0;
  assign bus.o_Spikesdata_valid = out_valid;
  assign bus.o_SpikesdataQuery  = out_query;
  assign bus.o_SpikesdataKey    = out_key;
  assign bus.o_key_idx          = out_key_idx;
  assign bus.o_last_chunk       = out_last_chunk;
  assign bus.o_last_key         = out_last_key;
endmodule

// File: tb/tb_attn_qk_spike_feeder.sv
// Bench for attn_qk_spike_feeder: RAM words equal their address, runs driven from a vector table.
module tb_attn_qk_spike_feeder;
  localparam int W      = 128;
  localparam int CHUNKS = 12;
  localparam int TOKENS = 64;
  localparam int BEATS  = CHUNKS * TOKENS;

  logic s_clk = 1'b0;
  logic s_rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  attn_qk_spike_feeder_if bus ();

  attn_qk_spike_feeder dut (
    .s_clk (s_clk),
    .s_rst (s_rst),
    .bus   (bus.master)
  );

  always #5 s_clk = ~s_clk;

  // RAMs whose content at each address is the address itself, one cycle read latency.
  always @(posedge s_clk) begin
    if (bus.o_q_rd_en) bus.i_q_rd_data <= W'(bus.o_q_rd_addr);
    if (bus.o_k_rd_en) bus.i_k_rd_data <= W'(bus.o_k_rd_addr);
  end

  typedef struct {
    int q;
    int hold_at;
    int hold_len;
    int mid_at;
    int rst_at;
    bit exp_err;
    int exp_beats;
    int exp_done_lat;
    int exp_gap;
  } run_t;

  run_t tbl[7];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, bus.o_busy, 0);
    check({tag, "_done"}, bus.o_done, 0);
    check({tag, "_valid"}, bus.o_Spikesdata_valid, 0);
    check({tag, "_rd_en"}, {bus.o_q_rd_en, bus.o_k_rd_en}, 0);
    check({tag, "_tags"}, {bus.o_key_idx, bus.o_last_chunk, bus.o_last_key}, 0);
  endtask

  task automatic run_vec(input int idx, input run_t r);
    int cyc = 0, issued = 0, beats = 0, first_rd = -1, last_beat = -1;
    int gaps = 0, hold_left = 0;
    bit done_seen = 0, hold_used = 0, mid_used = 0;
    logic [W-1:0] last_q = '0, last_k = '0;

    @(negedge s_clk);
    bus.i_start   = 1'b1;
    bus.i_q_token = 7'(r.q);

    if (r.exp_err) begin
      @(negedge s_clk);
      bus.i_start = 1'b0;
      check("err_pulse", bus.o_err, 1);
      check("err_busy", bus.o_busy, 0);
      check("err_rd_en", {bus.o_q_rd_en, bus.o_k_rd_en}, 0);
      repeat (5) begin
        @(negedge s_clk);
        check("err_clear", bus.o_err, 0);
        check("err_busy_after", bus.o_busy, 0);
        check("err_no_rd", {bus.o_q_rd_en, bus.o_k_rd_en}, 0);
      end
      return;
    end

    while (!done_seen && cyc < 3000) begin
      @(negedge s_clk);
      cyc++;
      check("busy_run", bus.o_busy, 1);
      check("rd_en_pair", bus.o_q_rd_en, bus.o_k_rd_en);
      if (bus.o_q_rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        check("q_addr", bus.o_q_rd_addr, r.q * CHUNKS + issued % CHUNKS);
        check("k_addr", bus.o_k_rd_addr, issued);
        issued++;
      end
      if (bus.o_Spikesdata_valid) begin
        if (beats == 0) check("first_latency", cyc - first_rd, 2);
        check("query", bus.o_SpikesdataQuery, W'(r.q * CHUNKS + beats % CHUNKS));
        check("key", bus.o_SpikesdataKey, W'(beats));
        check("key_idx", bus.o_key_idx, beats / CHUNKS);
        check("last_chunk", bus.o_last_chunk, (beats % CHUNKS) == CHUNKS - 1);
        check("last_key", bus.o_last_key, beats == BEATS - 1);
        last_q = W'(r.q * CHUNKS + beats % CHUNKS);
        last_k = W'(beats);
        beats++;
        last_beat = cyc;
      end else begin
        check("idle_tags", {bus.o_key_idx, bus.o_last_chunk, bus.o_last_key}, 0);
        if (beats > 0) begin
          check("query_hold", bus.o_SpikesdataQuery, last_q);
          check("key_hold", bus.o_SpikesdataKey, last_k);
          if (beats < BEATS) gaps++;
        end
      end
      if (bus.o_done) begin
        done_seen = 1;
        check("done_after_last", cyc - last_beat, 1);
        check("beat_count", beats, r.exp_beats);
        check("done_latency", cyc - first_rd, r.exp_done_lat);
        check("valid_gap", gaps, r.exp_gap);
      end

      if (r.rst_at > 0 && beats == r.rst_at) begin
        s_rst = 1'b1;
        #1;
        check_idle_outputs("rst_now");
        check("rst_data", {bus.o_SpikesdataQuery, bus.o_SpikesdataKey}, 0);
        check("rst_err", bus.o_err, 0);
        check("rst_beats", beats, r.exp_beats);
        @(negedge s_clk);
        s_rst      = 1'b0;
        bus.i_hold = 1'b0;
        bus.i_start = 1'b0;
        repeat (10) begin
          @(negedge s_clk);
          check_idle_outputs("post_rst");
        end
        return;
      end

      bus.i_start = 1'b0;
      if (r.mid_at > 0 && !mid_used && issued == r.mid_at) begin
        bus.i_start   = 1'b1;
        bus.i_q_token = 7'd7;
        mid_used      = 1;
      end
      if (r.hold_len > 0 && !hold_used && issued == r.hold_at) begin
        hold_left = r.hold_len;
        hold_used = 1;
      end
      bus.i_hold = (hold_left > 0);
      if (hold_left > 0) hold_left--;
    end

    if (!done_seen) begin
      check("done_timeout", 0, 1);
    end else begin
      @(negedge s_clk);
      check_idle_outputs("after_done");
    end
  endtask

  initial begin
    //          q  hold_at len mid rst err beats  lat  gap
    tbl[0] = '{ 3,  0,      0,  0,  0,  0,  BEATS, 770, 0};
    tbl[1] = '{ 3,  30,     5,  0,  0,  0,  BEATS, 775, 5};
    tbl[2] = '{ 3,  0,      0,  200, 0, 0,  BEATS, 770, 0};
    tbl[3] = '{ 64, 0,      0,  0,  0,  1,  0,     0,   0};
    tbl[4] = '{ 3,  0,      0,  0,  100, 0, 100,   0,   0};
    tbl[5] = '{ 0,  0,      0,  0,  0,  0,  BEATS, 770, 0};
    tbl[6] = '{ 63, 767,    2,  0,  0,  0,  BEATS, 772, 2};

    bus.i_start     = 1'b0;
    bus.i_q_token   = '0;
    bus.i_hold      = 1'b0;
    bus.i_q_rd_data = '0;
    bus.i_k_rd_data = '0;
    repeat (2) @(negedge s_clk);
    check_idle_outputs("reset");
    check("reset_err", bus.o_err, 0);
    check("reset_data", {bus.o_SpikesdataQuery, bus.o_SpikesdataKey}, 0);
    s_rst = 1'b0;
    @(negedge s_clk);
    check_idle_outputs("post_reset");

    for (int i = 0; i < 7; i++) run_vec(i, tbl[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
